// File: rtl/vga_pkg.sv
// vga_pkg: frame geometry, bus widths and arbiter state encoding shared by the VGA write-port blocks
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] CLEAR_VALUE = 8'h00;
  typedef enum logic {SERVE, CLEAR} state_t;
endpackage

// File: rtl/vga_wport_arbiter_if.sv
// vga_wport_arbiter_if: plot requests, clear control and frame-buffer write bus of the write-port arbiter
interface vga_wport_arbiter_if;
  import vga_pkg::*;
  logic clear_start, clear_busy, clear_done;
  logic p0_valid, p0_ready, p1_valid, p1_ready;
  logic [ADDR_W-1:0] p0_addr, p1_addr, vga_waddr;
  logic [DATA_W-1:0] p0_data, p1_data, dina;
  logic wea;
  logic [7:0] oob_count;
  modport master (
    output clear_start, p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
    input clear_busy, clear_done, p0_ready, p1_ready, vga_waddr, dina, wea, oob_count
  );
  modport slave (
    input clear_start, p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
    output clear_busy, clear_done, p0_ready, p1_ready, vga_waddr, dina, wea, oob_count
  );
endinterface

// File: rtl/vga_clear_seq.sv
// vga_clear_seq: sweeps every frame-buffer address once, one per cycle, flagging the final pixel
module vga_clear_seq #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic [vga_pkg::ADDR_W-1:0] addr
);
  localparam int COL_W = $clog2(H_ACTIVE);
  localparam int ROW_W = $clog2(V_ACTIVE);
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic col_end, pre_last;
  assign col_end = col == COL_W'(H_ACTIVE - 1);
  // done is registered, so it is raised one pixel ahead of the last one
  assign pre_last = row == ROW_W'(V_ACTIVE - 1) && col == COL_W'(H_ACTIVE - 2);
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      row <= '0;
      col <= '0;
      addr <= '0;
    end else if (busy) begin
      busy <= !done;
      done <= !done && pre_last;
      if (!done) begin
        col <= col_end ? '0 : col + 1'b1;
        row <= col_end ? row + 1'b1 : row;
        addr <= addr + 1'b1;
      end
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      row <= '0;
      col <= '0;
      addr <= '0;
    end
  end
endmodule

// File: rtl/vga_wport_arbiter.sv
// vga_wport_arbiter: round-robin arbiter for two plotters plus a full-frame clear on one BRAM write port
module vga_wport_arbiter #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter logic [vga_pkg::DATA_W-1:0] CLEAR_VALUE = vga_pkg::CLEAR_VALUE
) (
  input logic clk,
  input logic reset,
  vga_wport_arbiter_if.slave bus
);
  import vga_pkg::*;
  localparam int FRAME = H_ACTIVE * V_ACTIVE;
  state_t state;
  logic last_p1, serve, gnt, in_rng, clr_start, clr_busy, clr_done, wr_q;
  logic [ADDR_W-1:0] g_addr, clr_addr, wa_q;
  logic [DATA_W-1:0] g_data, wd_q;
  logic [7:0] oob_q;
  assign serve = state == SERVE && !bus.clear_start;
  assign bus.p0_ready = serve && bus.p0_valid && (!bus.p1_valid || last_p1);
  assign bus.p1_ready = serve && bus.p1_valid && (!bus.p0_valid || !last_p1);
  assign gnt = bus.p0_ready || bus.p1_ready;
  assign g_addr = bus.p1_ready ? bus.p1_addr : bus.p0_addr;
  assign g_data = bus.p1_ready ? bus.p1_data : bus.p0_data;
  assign in_rng = g_addr < ADDR_W'(FRAME);
  assign clr_start = state == SERVE && bus.clear_start;
  vga_clear_seq #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_clear (
    .clk(clk), .reset(reset), .start(clr_start), .busy(clr_busy), .done(clr_done), .addr(clr_addr)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SERVE;
      last_p1 <= 1'b1;
      wr_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      oob_q <= '0;
    end else begin
      state <= clr_start ? CLEAR : (state == CLEAR && clr_done) ? SERVE : state;
      wr_q <= gnt && in_rng;
      if (gnt) last_p1 <= bus.p1_ready;
      if (gnt && in_rng) begin
        wa_q <= g_addr;
        wd_q <= g_data;
      end
      if (gnt && !in_rng) oob_q <= oob_q + {7'd0, oob_q != 8'hff};
      // keep the last clear pixel on the bus once the sweep hands back to SERVE
      if (clr_done) begin
        wa_q <= clr_addr;
        wd_q <= CLEAR_VALUE;
      end
    end
  end
  assign bus.wea = wr_q || clr_busy;
  assign bus.vga_waddr = clr_busy ? clr_addr : wa_q;
  assign bus.dina = clr_busy ? CLEAR_VALUE : wd_q;
  assign bus.clear_busy = clr_busy;
  assign bus.clear_done = clr_done;
  assign bus.oob_count = oob_q;
endmodule

// File: tb/tb_vga_wport_arbiter.sv
// tb_vga_wport_arbiter: scoreboard bench for the write-port arbiter on a reduced 64x20 frame
module tb_vga_wport_arbiter;
  import vga_pkg::*;
  localparam int H = 64;
  localparam int V = 20;
  localparam int FRAME = H * V;
  typedef struct {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  vga_wport_arbiter_if bus();
  vga_wport_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .CLEAR_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  wr_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  logic m_clear, m_last_p1;
  int m_cnt, m_oob;
  logic [ADDR_W-1:0] h_a;
  logic [DATA_W-1:0] h_d;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_init();
    q.delete();
    m_clear = 1'b0;
    m_last_p1 = 1'b1;
    m_cnt = 0;
    m_oob = 0;
    h_a = '0;
    h_d = '0;
  endtask
  // reference model: evaluates the current cycle's outputs, then decides this cycle's grant
  always @(negedge clk) if (mon_en) begin
    logic g0, g1, both;
    logic [ADDR_W-1:0] a;
    wr_t e;
    if (m_clear) q.push_back('{ADDR_W'(m_cnt), CLEAR_VALUE});
    chk("clear_busy", bus.clear_busy, m_clear);
    chk("clear_done", bus.clear_done, m_clear && m_cnt == FRAME - 1);
    chk("wea", bus.wea, q.size() != 0);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("waddr", bus.vga_waddr, e.a);
      chk("dina", bus.dina, e.d);
      h_a = e.a;
      h_d = e.d;
    end else begin
      chk("hold_waddr", bus.vga_waddr, h_a);
      chk("hold_dina", bus.dina, h_d);
    end
    chk("oob_count", bus.oob_count, m_oob);
    both = bus.p0_valid && bus.p1_valid;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!m_clear && !bus.clear_start) begin
      if (both) begin
        if (m_last_p1) g0 = 1'b1; else g1 = 1'b1;
      end else begin
        g0 = bus.p0_valid;
        g1 = bus.p1_valid;
      end
    end
    chk("p0_ready", bus.p0_ready, g0);
    chk("p1_ready", bus.p1_ready, g1);
    if (g0 || g1) begin
      a = g1 ? bus.p1_addr : bus.p0_addr;
      if (int'(a) < FRAME) q.push_back('{a, g1 ? bus.p1_data : bus.p0_data});
      else if (m_oob < 255) m_oob++;
      m_last_p1 = g1;
    end
    if (m_clear) begin
      if (m_cnt == FRAME - 1) m_clear = 1'b0; else m_cnt++;
    end else if (bus.clear_start) begin
      m_clear = 1'b1;
      m_cnt = 0;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int t = 0;
    if (p == 0) begin
      bus.p0_valid = 1'b1; bus.p0_addr = a; bus.p0_data = d;
    end else begin
      bus.p1_valid = 1'b1; bus.p1_addr = a; bus.p1_data = d;
    end
    do begin
      @(negedge clk);
      t++;
    end while (!(p == 0 ? bus.p0_ready : bus.p1_ready) && t < 4000);
    chk($sformatf("accept_p%0d", p), p == 0 ? bus.p0_ready : bus.p1_ready, 1);
    @(posedge clk);
    #1;
    if (p == 0) bus.p0_valid = 1'b0; else bus.p1_valid = 1'b0;
  endtask
  initial begin
    bus.clear_start = 1'b0;
    bus.p0_valid = 1'b0; bus.p0_addr = '0; bus.p0_data = '0;
    bus.p1_valid = 1'b0; bus.p1_addr = '0; bus.p1_data = '0;
    cyc(3);
    chk("rst_wea", bus.wea, 0);
    chk("rst_busy", bus.clear_busy, 0);
    chk("rst_done", bus.clear_done, 0);
    chk("rst_waddr", bus.vga_waddr, 0);
    chk("rst_dina", bus.dina, 0);
    chk("rst_oob", bus.oob_count, 0);
    reset = 1'b0;
    model_init();
    mon_en = 1'b1;
    cyc(1);
    fork
      send(0, 19'd1000, 8'hFF);
      begin #1 chk("t1_same_cycle_ready", bus.p0_ready, 1); end
    join
    cyc(2);
    fork
      for (int i = 0; i < 6; i++) send(0, ADDR_W'(100 + i), DATA_W'(8'h10 + i));
      for (int j = 0; j < 6; j++) send(1, ADDR_W'(200 + j), DATA_W'(8'h20 + j));
    join
    cyc(2);
    bus.clear_start = 1'b1;
    cyc(1);
    bus.clear_start = 1'b0;
    cyc(100);
    bus.clear_start = 1'b1;
    cyc(1);
    bus.clear_start = 1'b0;
    send(1, 19'd500, 8'h5A);
    cyc(2);
    chk("t4_busy_low", bus.clear_busy, 0);
    bus.clear_start = 1'b1;
    fork
      send(0, 19'd777, 8'hC3);
      begin cyc(1); bus.clear_start = 1'b0; end
    join
    cyc(2);
    send(0, ADDR_W'(FRAME - 1), 8'h77);
    send(0, ADDR_W'(FRAME), 8'h11);
    send(1, '1, 8'h33);
    for (int i = 0; i < 300; i++)
      send(i % 2, ADDR_W'($urandom_range(524287, FRAME)), DATA_W'($urandom));
    cyc(2);
    chk("oob_saturated", bus.oob_count, 255);
    bus.clear_start = 1'b1;
    cyc(1);
    bus.clear_start = 1'b0;
    cyc(50);
    mon_en = 1'b0;
    reset = 1'b1;
    cyc(1);
    chk("midclr_rst_wea", bus.wea, 0);
    chk("midclr_rst_busy", bus.clear_busy, 0);
    chk("midclr_rst_done", bus.clear_done, 0);
    chk("midclr_rst_waddr", bus.vga_waddr, 0);
    chk("midclr_rst_dina", bus.dina, 0);
    chk("midclr_rst_oob", bus.oob_count, 0);
    cyc(2);
    reset = 1'b0;
    model_init();
    mon_en = 1'b1;
    cyc(20);
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
